decode38_seq: RTL
=================

DECODE38_SEQ -- requirements
Module: decode38_seq

Interface
REQ-001 Parameter DEPTH, 4, code queue depth in entries (power of 2, >=2).
REQ-002 Parameter HW, 4, width of the hold input and the hold counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  global enable; 0 = block paused.
REQ-006 in_valid  input  1  producer presents a code this cycle.
REQ-007 in_code  input  3  binary code to decode (0..7).
REQ-008 in_any  input  1  indicator bit; 0 = "no active input", decodes to a blank slot.
REQ-009 hold  input  HW  extra display cycles per entry, sampled at pop.
REQ-010 in_ready  output  1  queue accepts a code this cycle.
REQ-011 y  output  8  registered one-hot decode of the displayed entry.
REQ-012 y_valid  output  1  registered; y holds a displayed entry.
REQ-013 code_out  output  3  registered in_code of the displayed entry.
REQ-014 level  output  clog2(DEPTH)+1  current queue occupancy.

Function
REQ-015 in_ready SHALL equal en AND (level < DEPTH) AND NOT rst; combinational.
REQ-016 Push SHALL occur on an edge where in_valid=1 and in_ready=1, storing {in_any, in_code} at the tail.
REQ-017 A full queue SHALL refuse a push even if a pop occurs on the same edge.
REQ-018 Entries SHALL be displayed in strict FIFO order; none dropped, none duplicated.
REQ-019 FSM states: IDLE (y_valid=0) and SHOW (y_valid=1).
REQ-020 IDLE, en=1, level>0: on the next edge, pop head, load y/code_out, load counter with hold, go SHOW.
REQ-021 IDLE, level=0: remain IDLE, y=8'h00.
REQ-022 Latency: code pushed at edge N SHALL appear on y after edge N+1 when queue was empty and state IDLE.
REQ-023 Decode: in_any=1 -> y = 8'b1 << in_code; in_any=0 -> y = 8'h00 with y_valid=1 (blank slot); code_out = stored code in both cases.
REQ-024 SHOW, en=1, counter>0: decrement counter; y unchanged.
REQ-025 SHOW, en=1, counter=0, level>0: pop next entry on the same edge, stay SHOW; no idle gap between entries.
REQ-026 SHOW, en=1, counter=0, level=0: y <= 8'h00, y_valid <= 0, go IDLE.
REQ-027 Each entry SHALL be displayed for exactly hold+1 enabled cycles; hold=0 gives 1 cycle.
REQ-028 Changes to hold during SHOW SHALL NOT affect the entry in progress.
REQ-029 en=0: no push, no pop, counter frozen, y/y_valid/code_out/level held.
REQ-030 Simultaneous push and pop (level < DEPTH) SHALL leave level unchanged; head/tail pointers wrap modulo DEPTH.
REQ-031 y SHALL have at most one bit set in every cycle.

Reset
REQ-032 rst asserted SHALL immediately force: state IDLE, level=0, pointers 0, counter 0, y=8'h00, y_valid=0, code_out=0, in_ready=0.
REQ-033 rst asserted mid-SHOW or with a non-empty queue SHALL discard all queued and displayed entries.
REQ-034 After rst deasserts, the first push SHALL follow REQ-022 timing.

Verification
REQ-035 Reset, en=1, hold=0, push code 5 (in_any=1) at edge N -> y=8'h20, y_valid=1, code_out=5 after edge N+1; y=8'h00, y_valid=0 after edge N+2.
REQ-036 hold=2, push 0,3,7 on consecutive edges -> y=8'h01 x3 cycles, 8'h08 x3, 8'h80 x3, no gaps, then IDLE; level peaks at 2.
REQ-037 hold=15, push 6 codes with in_valid held high -> in_ready drops to 0 when level=4; no code lost or duplicated; order preserved.
REQ-038 Push in_any=0, code 4 -> y=8'h00, y_valid=1, code_out=4 for hold+1 cycles.
REQ-039 During SHOW of code 2 (hold=3), drop en for 5 cycles -> y stays 8'h04, counter frozen; total enabled display time still 4 cycles.
REQ-040 Assert rst asynchronously mid-SHOW with level=3 -> y=8'h00, y_valid=0, level=0, in_ready=0 before next clock edge.

Source files
------------

// File: rtl/decode38_seq.sv
// decode38_seq: queued 3-to-8 one-hot display sequencer.
// Codes are pushed into a small FIFO and shown one at a time on y.
// Each entry stays on the display for hold+1 enabled cycles.
// An entry with in_any=0 shows as a blank slot: y=0, y_valid=1.
module decode38_seq #(
    parameter int DEPTH = 4,
    parameter int HW    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       in_valid,
    input  logic [2:0]                 in_code,
    input  logic                       in_any,
    input  logic [HW-1:0]              hold,
    output logic                       in_ready,
    output logic [7:0]                 y,
    output logic                       y_valid,
    output logic [2:0]                 code_out,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LV_ZERO  = {LW{1'b0}};
    localparam logic [LW-1:0] LV_ONE   = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] LV_FULL  = LW'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [HW-1:0] CNT_ZERO = {HW{1'b0}};
    localparam logic [HW-1:0] CNT_ONE  = {{(HW-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    // One-hot decode of a stored entry; a blank entry decodes to all zeros.
    function automatic logic [7:0] f_decode(input logic i_any, input logic [2:0] i_code);
        logic [7:0] v_out;
        v_out = 8'h00;
        if (i_any) begin
            case (i_code)
                3'd0:    v_out = 8'h01;
                3'd1:    v_out = 8'h02;
                3'd2:    v_out = 8'h04;
                3'd3:    v_out = 8'h08;
                3'd4:    v_out = 8'h10;
                3'd5:    v_out = 8'h20;
                3'd6:    v_out = 8'h40;
                3'd7:    v_out = 8'h80;
                default: v_out = 8'h00;
            endcase
        end else begin
            v_out = 8'h00;
        end
        return v_out;
    endfunction

    // Queue storage and pointers
    logic [3:0]    r_mem [DEPTH];
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [LW-1:0] r_level;

    // Display state
    state_t        r_state;
    logic [HW-1:0] r_cnt;
    logic [7:0]    r_y;
    logic          r_y_valid;
    logic [2:0]    r_code;

    // Next-state wires
    state_t        w_state_nxt;
    logic [HW-1:0] w_cnt_nxt;
    logic [7:0]    w_y_nxt;
    logic          w_y_valid_nxt;
    logic [2:0]    w_code_nxt;
    logic          w_pop;
    logic          w_push;
    logic          w_ready;
    logic          w_has;
    logic [3:0]    w_head;

    assign w_ready  = en & (r_level < LV_FULL) & ~rst;
    assign w_push   = in_valid & w_ready;
    assign w_has    = (r_level != LV_ZERO);
    assign w_head   = r_mem[r_head];

    assign in_ready = w_ready;
    assign y        = r_y;
    assign y_valid  = r_y_valid;
    assign code_out = r_code;
    assign level    = r_level;

    // Display FSM next-state and output logic; pops the head when a new entry is due.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_y_nxt       = r_y;
        w_y_valid_nxt = r_y_valid;
        w_code_nxt    = r_code;
        w_pop         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en && w_has) begin
                    w_pop         = 1'b1;
                    w_y_nxt       = f_decode(w_head[3], w_head[2:0]);
                    w_y_valid_nxt = 1'b1;
                    w_code_nxt    = w_head[2:0];
                    w_cnt_nxt     = hold;
                    w_state_nxt   = ST_SHOW;
                end else begin
                    w_y_nxt       = 8'h00;
                    w_y_valid_nxt = 1'b0;
                end
            end
            ST_SHOW: begin
                if (!en) begin
                    w_cnt_nxt = r_cnt;
                end else if (r_cnt != CNT_ZERO) begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end else if (w_has) begin
                    // Back-to-back entries: next head is loaded on the same edge.
                    w_pop         = 1'b1;
                    w_y_nxt       = f_decode(w_head[3], w_head[2:0]);
                    w_y_valid_nxt = 1'b1;
                    w_code_nxt    = w_head[2:0];
                    w_cnt_nxt     = hold;
                end else begin
                    w_y_nxt       = 8'h00;
                    w_y_valid_nxt = 1'b0;
                    w_state_nxt   = ST_IDLE;
                end
            end
            default: begin
                w_y_nxt       = 8'h00;
                w_y_valid_nxt = 1'b0;
                w_cnt_nxt     = CNT_ZERO;
                w_state_nxt   = ST_IDLE;
            end
        endcase
    end

    // FSM state, hold counter and registered display outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= CNT_ZERO;
            r_y       <= 8'h00;
            r_y_valid <= 1'b0;
            r_code    <= 3'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_y       <= w_y_nxt;
            r_y_valid <= w_y_valid_nxt;
            r_code    <= w_code_nxt;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= {AW{1'b0}};
            r_tail  <= {AW{1'b0}};
            r_level <= LV_ZERO;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_ONE;
            end
            if (w_pop) begin
                r_head <= r_head + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LV_ONE;
                2'b01:   r_level <= r_level - LV_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Queue data write; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= {in_any, in_code};
        end
    end

endmodule
